parser_in_arb: RTL and testbench
================================

# parser_in_arb

Packet-level round-robin arbiter that shares the single `parser` input port between several packet sources. Each source presents 32-bit packet beats with valid/last/ready handshakes in the same header format the parser consumes: word 0 is {length LE, stream LE} and word 1 is the sequence number LE. The arbiter grants one source for a whole packet, from the first beat through the beat with last, so beats of different packets never interleave at the parser. It sits directly in front of `parser`, and its output drives `dataIn`, `dataIn_val`, `dataIN_last` and `dataIn_ready`.

## Interface
- `N_SRC`, default 4: number of requesting sources (2..8).
- `DATA_W`, default 32: beat width. Must match the parser input.
- `CNT_W`, default 16: packet-counter width. Used only with `PARSER_ARB_PKTCNT_EN`.

- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `srcData`, in, N_SRC*DATA_W: source beats. Source i occupies bits [i*DATA_W +: DATA_W].
- `srcData_val`, in, N_SRC: per-source beat valid.
- `srcData_last`, in, N_SRC: per-source last beat of packet.
- `srcData_ready`, out, N_SRC: per-source ready.
- `dataOut`, out, DATA_W: beat to parser `dataIn`.
- `dataOut_val`, out, 1: to parser `dataIn_val`.
- `dataOut_last`, out, 1: to parser `dataIN_last`.
- `dataOut_ready`, in, 1: from parser `dataIn_ready`.
- `grant`, out, N_SRC: one-hot current owner. All zeros when idle.
- `busy`, out, 1: high while in ARB_GRANT.
- `pktCount`, out, N_SRC*CNT_W: per-source completed-packet counters. Present only with `PARSER_ARB_PKTCNT_EN`.

## Operation
- FSM has two states: ARB_IDLE and ARB_GRANT.
- **ARB_IDLE:**
  - `grant`=0, all `srcData_ready`=0, `dataOut_val`=0.
  - If any `srcData_val` is set, the round-robin pick selects the first requesting source searching upward from `rrPtr+1` mod N_SRC.
  - On the next edge: `grant` is set, `rrPtr` is set to the winner, and the FSM goes to ARB_GRANT.
- **ARB_GRANT** (owner g):
  - Combinational mux: `dataOut`/`dataOut_val`/`dataOut_last` = source g's signals.
  - `srcData_ready[g]` = `dataOut_ready`. All other ready bits are 0.
  - A beat transfers when `dataOut_val` && `dataOut_ready`.
  - A transfer with `dataOut_last` set ends the packet. The FSM returns to ARB_IDLE on that edge and `grant` clears.
- Requests are sampled only in ARB_IDLE. A source raising valid mid-packet of another source waits.
- If the owner drops valid mid-packet, the grant is held indefinitely. There is no timeout and no abort.
- The arbiter never inspects header contents. Length and sequence checking remain the parser's job.
- With a single requester, that source wins every arbitration.
- With all sources requesting continuously, the grant order is 0,1,2,3,0,…

## Timing
- Reset values:
  - `grant`=0, `busy`=0, `srcData_ready`=0, `dataOut_val`=0, `dataOut_last`=0, `dataOut`=0.
  - `rrPtr`=N_SRC-1, so source 0 wins the first arbitration.
  - `pktCount`=0.
- Arbitration latency: 1 cycle (ARB_IDLE) between packets. A request at edge k is granted at edge k+1, and the first beat can transfer in cycle k+1.
- Datapath latency: zero cycles, combinational from source to parser. No registers on data.
- Reset asserted mid-packet: the grant drops immediately (asynchronously). The partial packet is not completed, and the source must restart it after reset.
- A single-beat packet (val and last on the first beat) is legal: ARB_GRANT lasts one cycle if ready is high.
- A `dataOut_ready` stall holds the mux and owner unchanged, with no beat loss.

## Configuration
- `PARSER_ARB_PKTCNT_EN`:
  - **Defined:** `pktCount` port exists. Counter i increments on each last-beat transfer from source i and wraps at 2^CNT_W-1 → 0.
  - **Undefined:** the port and the counters are absent. Arbitration behaviour is identical in both cases.

## Structure
- `parser_pkg` holds:
  - `DATA_W` default constant.
  - Header field positions (length bits [31:16] byte-swapped, stream bits [15:0] byte-swapped).
  - `arb_state_t` enum {ARB_IDLE, ARB_GRANT}.
- Sub-module `parser_rr_pick`: combinational, takes request vector and pointer, returns one-hot winner and index.

## Test plan
- **Reset:** hold reset 5 cycles → all outputs 0. Release with only src0 requesting → `grant`=0001 one cycle after the request.
- **Two requesters:** src0 sends stream 12, seq 1, 20 B (5 beats) while src1 sends stream 13, seq 1, 24 B → src0's 5 beats, then 1 idle cycle, then src1's 6 beats, with no interleave. With `PARSER_ARB_PKTCNT_EN`, `pktCount[0]`=1 and `pktCount[1]`=1.
- **Fairness:** all 4 sources request 2-beat packets continuously → grant order 0,1,2,3,0,1.
- **Backpressure:** `dataOut_ready` toggles 1010 during a 5-beat packet → all 5 beats arrive in order, and `srcData_ready` of the owner mirrors `dataOut_ready`.
- **Mid-packet reset:** assert reset on beat 3 of src2 → `grant`=0 immediately. After release with src2 and src3 requesting, src0-first ordering resumes (`rrPtr`=N_SRC-1), so src2 wins.
- **Counter wrap** (macro on, CNT_W=4): 17 packets from src1 → `pktCount[1]`=1.

Source files
------------

// File: rtl/parser_pkg.sv
// Shared definitions for the parser input path: default beat width, header field
// layout and the input-arbiter state encoding.
package parser_pkg;

    localparam int PARSER_DATA_W = 32;

    // Header word 0 carries {length, stream}, each 16-bit field stored little-endian.
    localparam int HDR_LEN_MSB    = 31;
    localparam int HDR_LEN_LSB    = 16;
    localparam int HDR_STREAM_MSB = 15;
    localparam int HDR_STREAM_LSB = 0;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    function automatic logic [15:0] bswap16(input logic [15:0] v);
        return {v[7:0], v[15:8]};
    endfunction

    function automatic logic [15:0] hdr_length(input logic [31:0] w0);
        return bswap16(w0[HDR_LEN_MSB:HDR_LEN_LSB]);
    endfunction

    function automatic logic [15:0] hdr_stream(input logic [31:0] w0);
        return bswap16(w0[HDR_STREAM_MSB:HDR_STREAM_LSB]);
    endfunction

endpackage

// File: rtl/parser_rr_pick.sv
// Round-robin pick: first requester searching upward from ptr+1 (mod N_SRC),
// returned both one-hot and as an index.
module parser_rr_pick #(
    parameter int N_SRC = 4,
    parameter int IDX_W = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_SRC-1:0] win_onehot,
    output logic [IDX_W-1:0] win_idx,
    output logic             win_any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        win_any    = 1'b0;
        cand       = '0;
        for (int k = 1; k <= N_SRC; k++) begin
            cand = IDX_W'((int'(ptr) + k) % N_SRC);
            if (!win_any && req[cand]) begin
                win_any          = 1'b1;
                win_onehot[cand] = 1'b1;
                win_idx          = cand;
            end
        end
    end

endmodule

// File: rtl/parser_in_arb.sv
// Packet-level round-robin arbiter sharing the parser input among N_SRC sources.
// Per-source completed-packet counters are built only with PARSER_ARB_PKTCNT_EN.
//
// state     | meaning
// ARB_IDLE  | no owner; pick next requester, grant on the following edge
// ARB_GRANT | owner holds the port until its last beat transfers
module parser_in_arb
    import parser_pkg::*;
#(
    parameter int N_SRC  = 4,
    parameter int DATA_W = PARSER_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_SRC*DATA_W-1:0] srcData,
    input  logic [N_SRC-1:0]        srcData_val,
    input  logic [N_SRC-1:0]        srcData_last,
    output logic [N_SRC-1:0]        srcData_ready,
    output logic [DATA_W-1:0]       dataOut,
    output logic                    dataOut_val,
    output logic                    dataOut_last,
    input  logic                    dataOut_ready,
`ifdef PARSER_ARB_PKTCNT_EN
    output logic [N_SRC*CNT_W-1:0]  pktCount,
`endif
    output logic [N_SRC-1:0]        grant,
    output logic                    busy
);

    localparam int IDX_W = $clog2(N_SRC);

    arb_state_t       state_q, state_d;
    logic [N_SRC-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [N_SRC-1:0] pick_onehot;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             xfer_last;

    parser_rr_pick #(.N_SRC(N_SRC), .IDX_W(IDX_W)) u_pick (
        .req        (srcData_val),
        .ptr        (rr_ptr_q),
        .win_onehot (pick_onehot),
        .win_idx    (pick_idx),
        .win_any    (pick_any)
    );

    // grant_q is zero when idle, so the mux naturally drives zeros then.
    always_comb begin
        dataOut      = '0;
        dataOut_val  = 1'b0;
        dataOut_last = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (grant_q[i]) begin
                dataOut      = srcData[i*DATA_W +: DATA_W];
                dataOut_val  = srcData_val[i];
                dataOut_last = srcData_last[i];
            end
        end
    end

    assign srcData_ready = grant_q & {N_SRC{dataOut_ready}};
    assign xfer_last     = dataOut_val & dataOut_ready & dataOut_last;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_d  = ARB_GRANT;
                    grant_d  = pick_onehot;
                    rr_ptr_d = pick_idx;
                end
            end
            ARB_GRANT: begin
                if (xfer_last) begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ARB_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= IDX_W'(N_SRC - 1);
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q == ARB_GRANT);

`ifdef PARSER_ARB_PKTCNT_EN
    logic [CNT_W-1:0] cnt_q [N_SRC];
    logic [CNT_W-1:0] cnt_d [N_SRC];

    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            cnt_d[i] = cnt_q[i];
            if (xfer_last && grant_q[i]) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_SRC; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        pktCount = '0;
        for (int i = 0; i < N_SRC; i++) begin
            pktCount[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_parser_in_arb.sv
// Bench for parser_in_arb: directed scenarios plus random traffic, checked every
// cycle against a packet-level round-robin reference model and per-source scoreboards.
module tb_parser_in_arb;

    localparam int N  = 4;
    localparam int DW = 32;
`ifdef PARSER_ARB_PKTCNT_EN
    localparam int CW = 4;
`else
    localparam int CW = 16;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [N*DW-1:0]   srcData;
    logic [N-1:0]      srcData_val;
    logic [N-1:0]      srcData_last;
    logic [N-1:0]      srcData_ready;
    logic [DW-1:0]     dataOut;
    logic              dataOut_val;
    logic              dataOut_last;
    logic              dataOut_ready;
    logic [N-1:0]      grant;
    logic              busy;
`ifdef PARSER_ARB_PKTCNT_EN
    logic [N*CW-1:0]   pktCount;
`endif

    always #5 clk = ~clk;

    parser_in_arb #(.N_SRC(N), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .srcData       (srcData),
        .srcData_val   (srcData_val),
        .srcData_last  (srcData_last),
        .srcData_ready (srcData_ready),
        .dataOut       (dataOut),
        .dataOut_val   (dataOut_val),
        .dataOut_last  (dataOut_last),
        .dataOut_ready (dataOut_ready),
`ifdef PARSER_ARB_PKTCNT_EN
        .pktCount      (pktCount),
`endif
        .grant         (grant),
        .busy          (busy)
    );

    int checks = 0;
    int errors = 0;

    logic [32:0] txq  [N][$];
    logic [31:0] expq [N][$];
    logic [31:0] rxq  [N][$];

    int   val_pct;
    int   rdy_mode;
    logic rdy_tgl;

    bit   m_busy;
    int   m_owner;
    int   m_ptr;
    int   m_cnt [N];

    int        cyc;
    int        order_log [$];
    int        xfer_src [$];
    int        xfer_cyc [$];
    logic [N-1:0] prev_grant;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_next(input logic [N-1:0] req, input int ptr);
        for (int k = 1; k <= N; k++) begin
            if (req[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic int pending();
        int p = 0;
        for (int i = 0; i < N; i++) p += txq[i].size();
        return p;
    endfunction

    task automatic add_pkt(input int s, input logic [15:0] stream, input logic [31:0] seq,
                           input int nbeats);
        logic [15:0] len;
        logic [31:0] word;
        logic        lst;
        len = 16'(nbeats * 4);
        for (int b = 0; b < nbeats; b++) begin
            if (b == 0)      word = {len[7:0], len[15:8], stream[7:0], stream[15:8]};
            else if (b == 1) word = {seq[7:0], seq[15:8], seq[23:16], seq[31:24]};
            else             word = $urandom;
            lst = (b == nbeats - 1);
            txq[s].push_back({lst, word});
            expq[s].push_back(word);
        end
    endtask

    task automatic drive();
        logic [32:0] bt;
        for (int i = 0; i < N; i++) begin
            if (txq[i].size() > 0 && $urandom_range(99) < val_pct) begin
                bt = txq[i][0];
                srcData_val[i]          = 1'b1;
                srcData[i*DW +: DW]     = bt[31:0];
                srcData_last[i]         = bt[32];
            end else begin
                srcData_val[i]          = 1'b0;
                srcData[i*DW +: DW]     = $urandom;
                srcData_last[i]         = 1'($urandom);
            end
        end
        case (rdy_mode)
            0: dataOut_ready = 1'b1;
            1: begin
                dataOut_ready = rdy_tgl;
                rdy_tgl       = ~rdy_tgl;
            end
            default: dataOut_ready = 1'($urandom);
        endcase
    endtask

    task automatic check_and_update();
        logic [N-1:0]  e_grant;
        logic [N-1:0]  e_ready;
        logic          e_val;
        logic          e_last;
        logic [DW-1:0] e_data;
        int            w;
        e_grant = '0;
        e_ready = '0;
        e_val   = 1'b0;
        e_last  = 1'b0;
        e_data  = '0;
        if (m_busy) begin
            e_grant[m_owner] = 1'b1;
            e_ready[m_owner] = dataOut_ready;
            e_val            = srcData_val[m_owner];
            e_last           = srcData_last[m_owner];
            e_data           = srcData[m_owner*DW +: DW];
        end
        chk("grant", grant, e_grant);
        chk("busy", busy, m_busy);
        chk("src_ready", srcData_ready, e_ready);
        chk("out_val", dataOut_val, e_val);
        chk("out_last", dataOut_last, e_last);
        chk("out_data", dataOut, e_data);
`ifdef PARSER_ARB_PKTCNT_EN
        for (int i = 0; i < N; i++) chk($sformatf("pktcount%0d", i), pktCount[i*CW +: CW], m_cnt[i]);
`endif
        if (grant !== '0 && prev_grant === '0) begin
            for (int i = 0; i < N; i++) if (grant[i]) order_log.push_back(i);
        end
        prev_grant = grant;
        if (dataOut_val && dataOut_ready) begin
            for (int i = 0; i < N; i++) begin
                if (grant[i]) begin
                    rxq[i].push_back(dataOut);
                    xfer_src.push_back(i);
                    xfer_cyc.push_back(cyc);
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (srcData_val[i] && srcData_ready[i] && txq[i].size() > 0) void'(txq[i].pop_front());
        end
        if (m_busy) begin
            if (srcData_val[m_owner] && dataOut_ready && srcData_last[m_owner]) begin
                m_busy          = 1'b0;
                m_cnt[m_owner]  = (m_cnt[m_owner] + 1) % (1 << CW);
            end
        end else begin
            w = rr_next(srcData_val, m_ptr);
            if (w >= 0) begin
                m_busy  = 1'b1;
                m_owner = w;
                m_ptr   = w;
            end
        end
        cyc++;
    endtask

    task automatic step();
        drive();
        #1;
        check_and_update();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset         = 1'b1;
        srcData       = '0;
        srcData_val   = '0;
        srcData_last  = '0;
        dataOut_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            txq[i].delete();
            expq[i].delete();
            rxq[i].delete();
            m_cnt[i] = 0;
        end
        m_busy     = 1'b0;
        m_owner    = 0;
        m_ptr      = N - 1;
        prev_grant = '0;
        order_log.delete();
        xfer_src.delete();
        xfer_cyc.delete();
        repeat (n) @(posedge clk);
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", srcData_ready, 0);
        chk("rst_val", dataOut_val, 0);
        chk("rst_last", dataOut_last, 0);
        chk("rst_data", dataOut, 0);
`ifdef PARSER_ARB_PKTCNT_EN
        chk("rst_cnt", pktCount, 0);
`endif
        reset = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        for (int c = 0; c < budget; c++) begin
            if (pending() == 0 && !m_busy) break;
            step();
        end
        chk(tag, pending(), 0);
    endtask

    task automatic compare_rx(input string tag);
        int n;
        for (int s = 0; s < N; s++) begin
            chk($sformatf("%s_len%0d", tag, s), rxq[s].size(), expq[s].size());
            n = (rxq[s].size() < expq[s].size()) ? rxq[s].size() : expq[s].size();
            for (int k = 0; k < n; k++) chk($sformatf("%s_beat%0d_%0d", tag, s, k), rxq[s][k], expq[s][k]);
        end
    endtask

    initial begin
        val_pct  = 100;
        rdy_mode = 0;
        rdy_tgl  = 1'b1;
        cyc      = 0;

        // Reset, then a lone request from src0.
        do_reset(5);
        add_pkt(0, 16'd5, 32'd1, 3);
        step();
        chk("first_grant", grant, 4'b0001);
        drain("single_drain", 50);
        compare_rx("single");

        // Two simultaneous requesters: whole packets, one idle cycle between.
        do_reset(2);
        add_pkt(0, 16'd12, 32'd1, 5);
        add_pkt(1, 16'd13, 32'd1, 6);
        drain("two_drain", 100);
        compare_rx("two");
        chk("two_nxfer", xfer_src.size(), 11);
        if (xfer_src.size() == 11) begin
            for (int k = 0; k < 11; k++) chk($sformatf("two_src%0d", k), xfer_src[k], (k < 5) ? 0 : 1);
            for (int k = 1; k < 11; k++) chk($sformatf("two_gap%0d", k), xfer_cyc[k] - xfer_cyc[k-1], (k == 5) ? 2 : 1);
        end
`ifdef PARSER_ARB_PKTCNT_EN
        chk("two_cnt0", pktCount[0 +: CW], 1);
        chk("two_cnt1", pktCount[CW +: CW], 1);
`endif

        // Fairness with all sources requesting continuously.
        do_reset(2);
        for (int r = 0; r < 2; r++) begin
            for (int s = 0; s < N; s++) add_pkt(s, 16'(20 + s), 32'(r + 1), 2);
        end
        drain("fair_drain", 200);
        compare_rx("fair");
        chk("fair_ngrants", order_log.size(), 8);
        if (order_log.size() == 8) begin
            for (int k = 0; k < 8; k++) chk($sformatf("fair_order%0d", k), order_log[k], k % N);
        end

        // Backpressure: ready toggles 1,0,1,0 during a 5-beat packet.
        do_reset(2);
        rdy_mode = 1;
        rdy_tgl  = 1'b1;
        add_pkt(1, 16'd7, 32'd3, 5);
        drain("bp_drain", 100);
        compare_rx("bp");
        rdy_mode = 0;

        // Reset while src2 is presenting its third beat.
        do_reset(2);
        add_pkt(2, 16'd9, 32'd4, 5);
        for (int c = 0; c < 20; c++) begin
            if (rxq[2].size() >= 2) break;
            step();
        end
        chk("mid_two_beats", rxq[2].size(), 2);
        drive();
        #1;
        chk("mid_pre_grant", grant, 4'b0100);
        reset = 1'b1;
        #1;
        chk("mid_rst_grant", grant, 0);
        chk("mid_rst_ready", srcData_ready, 0);
        do_reset(3);
        add_pkt(2, 16'd9, 32'd4, 5);
        add_pkt(3, 16'd10, 32'd1, 3);
        step();
        chk("mid_resume_grant", grant, 4'b0100);
        drain("mid_drain", 100);
        compare_rx("mid");

        // Seventeen single-beat packets from src1.
        do_reset(2);
        for (int p = 0; p < 17; p++) add_pkt(1, 16'd5, 32'(p), 1);
        drain("wrap_drain", 200);
        compare_rx("wrap");
`ifdef PARSER_ARB_PKTCNT_EN
        chk("wrap_cnt1", pktCount[CW +: CW], 1);
`endif

        // Random traffic: gappy valids, random ready, mixed packet lengths.
        do_reset(2);
        val_pct  = 70;
        rdy_mode = 2;
        for (int s = 0; s < N; s++) begin
            for (int p = 0; p < 6; p++) add_pkt(s, 16'($urandom_range(0, 65535)), 32'(p), $urandom_range(1, 6));
        end
        drain("rand_drain", 3000);
        compare_rx("rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
